somador_sequencial: RTL and testbench

Parametrised multi-cycle adder/subtractor for the MIPS datapath. It processes an operand of WIDTH bits DIGIT bits per clock, reusing one DIGIT-bit ripple slice. It adds a start/busy/done handshake, a subtract mode and status flags (carry, signed overflow, zero). It trades latency for area against the fixed 8-bit combinational ripple adder and targets the ALU add/sub path and address arithmetic in the multi-cycle datapath.

---
 rtl/somador_sequencial_pkg.sv | 14 +
 rtl/somador_digito.sv | 43 ++++
 rtl/somador_sequencial.sv | 163 ++++++++++++++++
 tb/tb_somador_sequencial.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/somador_sequencial_pkg.sv
// Shared definitions for the sequential adder/subtractor and the ALU control:
// FSM state encoding and add/subtract mode constants.
package somador_sequencial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } estado_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/somador_digito.sv
// DIGIT-bit combinational ripple adder built from a chain of 1-bit full adders.
// The sequential adder reuses one instance of it for every slice.
module somador1bit (
  output logic s,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module somador_digito #(
  parameter int DIGIT = 8
) (
  output logic [DIGIT-1:0] S,
  output logic             Cout,
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  input  logic             Cin
);

  // c_s[i] is the carry into bit i; c_s[DIGIT] leaves the slice
  logic [DIGIT:0] c_s;

  assign c_s[0] = Cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    somador1bit u_bit (
      .s    (S[i]),
      .cout (c_s[i+1]),
      .a    (A[i]),
      .b    (B[i]),
      .cin  (c_s[i])
    );
  end

  assign Cout = c_s[DIGIT];

endmodule

// File: rtl/somador_sequencial.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands DIGIT bits per clock
// through a single shared ripple slice, with start/busy/done handshake and
// carry, signed-overflow and zero flags.
module somador_sequencial
  import somador_sequencial_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  estado_t          state_r;
  estado_t          state_next_s;

  // operands captured at start; opb_r already holds ~B when subtracting
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic             carry_r;
  logic             msba_r;
  logic             msbb_r;
  logic [CW-1:0]    cnt_r;

  logic [DIGIT-1:0] slice_a_s;
  logic [DIGIT-1:0] slice_b_s;
  logic [DIGIT-1:0] slice_sum_s;
  logic             slice_cout_s;
  logic [WIDTH-1:0] sum_next_s;
  logic             last_s;

  assign slice_a_s = opa_r[cnt_r*DIGIT +: DIGIT];
  assign slice_b_s = opb_r[cnt_r*DIGIT +: DIGIT];
  assign last_s    = (cnt_r == CNT_LAST);

  somador_digito #(
    .DIGIT (DIGIT)
  ) u_digito (
    .S    (slice_sum_s),
    .Cout (slice_cout_s),
    .A    (slice_a_s),
    .B    (slice_b_s),
    .Cin  (carry_r)
  );

  // Sum with the current slice merged in; on the last step this is the final result
  always_comb begin
    sum_next_s = Sum;
    sum_next_s[cnt_r*DIGIT +: DIGIT] = slice_sum_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: accept start only in IDLE, leave RUN after the last slice
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs: capture operands, add one slice per RUN edge,
  // publish flags and the done pulse on entry to DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      Sum      <= {WIDTH{1'b0}};
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
      opa_r    <= {WIDTH{1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      msba_r   <= 1'b0;
      msbb_r   <= 1'b0;
      cnt_r    <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            opa_r   <= A;
            opb_r   <= (sub == MODE_SUB) ? ~B : B;
            carry_r <= (sub == MODE_SUB) ? 1'b1 : Cin;
            msba_r  <= A[WIDTH-1];
            msbb_r  <= (sub == MODE_SUB) ? ~B[WIDTH-1] : B[WIDTH-1];
            cnt_r   <= CNT_ZERO;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          Sum     <= sum_next_s;
          carry_r <= slice_cout_s;
          cnt_r   <= cnt_r + CNT_ONE;
          if (last_s) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            Cout     <= slice_cout_s;
            Overflow <= (msba_r == msbb_r) && (sum_next_s[WIDTH-1] != msba_r);
            Zero     <= (sum_next_s == {WIDTH{1'b0}});
          end else begin
            busy <= 1'b1;
          end
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_somador_sequencial.sv
// Directed self-checking bench for somador_sequencial: 32/8 (4 steps),
// 8/8 (1 step) and 16/4 (4 steps) configurations.
module tb_somador_sequencial;

  logic clk;
  logic reset;

  logic        start32, sub32, cin32;
  logic [31:0] a32, b32, sum32;
  logic        busy32, done32, cout32, ovf32, zero32;

  logic        start8, sub8, cin8;
  logic [7:0]  a8, b8, sum8;
  logic        busy8, done8, cout8, ovf8, zero8;

  logic        start16, sub16, cin16;
  logic [15:0] a16, b16, sum16;
  logic        busy16, done16, cout16, ovf16, zero16;

  int n_cmp;
  int n_err;

  somador_sequencial #(.WIDTH(32), .DIGIT(8)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .sub(sub32), .A(a32), .B(b32), .Cin(cin32),
    .busy(busy32), .done(done32), .Sum(sum32), .Cout(cout32), .Overflow(ovf32), .Zero(zero32)
  );

  somador_sequencial #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .A(a8), .B(b8), .Cin(cin8),
    .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8), .Overflow(ovf8), .Zero(zero8)
  );

  somador_sequencial #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .sub(sub16), .A(a16), .B(b16), .Cin(cin16),
    .busy(busy16), .done(done16), .Sum(sum16), .Cout(cout16), .Overflow(ovf16), .Zero(zero16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic s);
    case (w)
      8: begin start8 = st; a8 = a[7:0]; b8 = b[7:0]; cin8 = ci; sub8 = s; end
      16: begin start16 = st; a16 = a[15:0]; b16 = b[15:0]; cin16 = ci; sub16 = s; end
      default: begin start32 = st; a32 = a; b32 = b; cin32 = ci; sub32 = s; end
    endcase
  endtask

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : (w == 16) ? busy16 : busy32;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : (w == 16) ? done16 : done32;
  endfunction

  function automatic logic [31:0] get_sum(input int w);
    return (w == 8) ? {24'd0, sum8} : (w == 16) ? {16'd0, sum16} : sum32;
  endfunction

  function automatic logic [2:0] get_flags(input int w);
    return (w == 8) ? {cout8, ovf8, zero8} : (w == 16) ? {cout16, ovf16, zero16}
                                                        : {cout32, ovf32, zero32};
  endfunction

  // One operation: start pulse, operands scrambled right after sampling,
  // optional start re-pulse during RUN; checks latency, busy length, result,
  // pulse width, hold and absence of a second operation.
  task automatic op(input int w, input logic [31:0] a, input logic [31:0] b, input logic ci,
                    input logic s, input logic [31:0] es, input logic ec, input logic eo,
                    input logic ez, input int exp_done, input bit repulse, input string tag);
    int busy_n;
    int done_at;
    int extra;
    busy_n  = 0;
    done_at = 0;
    extra   = 0;
    @(negedge clk);
    drive(w, 1'b1, a, b, ci, s);
    @(negedge clk);
    drive(w, 1'b0, ~a, ~b, ~ci, ~s);
    for (int k = 1; k <= 20 && done_at == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (repulse && k == 2) drive(w, 1'b1, 32'd100, 32'd200, 1'b0, 1'b0);
      if (repulse && k == 3) drive(w, 1'b0, 32'd100, 32'd200, 1'b0, 1'b0);
      if (get_busy(w)) busy_n++;
      if (get_done(w)) done_at = k;
    end
    chk({tag, "/done_at"}, done_at, exp_done);
    chk({tag, "/busy_cycles"}, busy_n, exp_done - 1);
    chk({tag, "/sum"}, get_sum(w), es);
    chk({tag, "/cout_ovf_zero"}, {29'd0, get_flags(w)}, {29'd0, ec, eo, ez});
    @(negedge clk);
    chk({tag, "/done_width"}, {31'd0, get_done(w)}, 32'd0);
    chk({tag, "/sum_hold"}, get_sum(w), es);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (get_done(w)) extra++;
    end
    chk({tag, "/no_extra_done"}, extra, 32'd0);
  endtask

  initial begin
    int d_pos [0:3];
    int n_done;
    int extra;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive(32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(16, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset/busy_done", {30'd0, busy32, done32}, 32'd0);
    chk("reset/sum", sum32, 32'd0);
    chk("reset/flags", {29'd0, cout32, ovf32, zero32}, 32'd0);
    chk("reset/sum8", {24'd0, sum8}, 32'd0);
    reset = 1'b0;

    // Basic add and wrap/overflow boundaries
    op(32, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 5, 1'b0, "add_ff_1");
    op(32, 32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0, 5, 1'b0, "add_cin");
    op(32, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 5, 1'b0, "add_ovf");
    op(32, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 5, 1'b0, "sub_ovf");
    op(32, 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 5, 1'b0, "sub_neg");
    op(32, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 5, 1'b0, "add_wrap");

    // Reset in the 2nd RUN cycle, after flags were left at Cout=1/Zero=1
    @(negedge clk);
    drive(32, 1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b0);
    @(negedge clk);
    drive(32, 1'b0, 32'h12345678, 32'h11111111, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset/busy_done", {30'd0, busy32, done32}, 32'd0);
    chk("midreset/sum", sum32, 32'd0);
    chk("midreset/flags", {29'd0, cout32, ovf32, zero32}, 32'd0);
    reset = 1'b0;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done32) extra++;
    end
    chk("midreset/no_done", extra, 32'd0);
    op(32, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 5, 1'b0, "after_reset");

    // start re-pulsed during RUN is ignored
    op(32, 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0, 5, 1'b1, "repulse");

    // start held high: back-to-back operations every 6 cycles
    n_done = 0;
    @(negedge clk);
    drive(32, 1'b1, 32'd10, 32'd20, 1'b0, 1'b0);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (done32) begin
        if (n_done < 4) d_pos[n_done] = k;
        n_done++;
        chk("held/sum", sum32, 32'd30);
      end
      if (k == 17) start32 = 1'b0;
    end
    chk("held/count", n_done, 32'd3);
    chk("held/first", d_pos[0], 32'd5);
    chk("held/second", d_pos[1], 32'd11);
    chk("held/third", d_pos[2], 32'd17);

    // Single-step and narrow-digit configurations
    op(8, 32'h000000C8, 32'h00000064, 1'b0, 1'b0, 32'h0000002C, 1'b1, 1'b0, 1'b0, 2, 1'b0, "w8_add");
    op(16, 32'h00000FFF, 32'h00000001, 1'b0, 1'b0, 32'h00001000, 1'b0, 1'b0, 1'b0, 5, 1'b0, "w16_add");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
